// File: rtl/adder_pkg.sv
// Shared definitions for the chunked adder: FSM encoding and configuration check.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Legal configuration: at least two result bits, whole number of chunks.
  function automatic bit width_ok(input int width, input int chunk);
    return (chunk >= 1) && (width >= 2) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_slice.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into its top bit.
module chunk_slice #(
  parameter int CHUNK = 8
) (
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb_in,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout    = c[CHUNK];
  assign cmsb_in = c[CHUNK-1];

endmodule

// File: rtl/chunk_adder_seq.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock
// through one reused ripple slice, with carry-out and signed-overflow flags.
module chunk_adder_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             over_flow,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("chunk_adder_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready and out_valid depend only on the state register, so neither
  // in_valid nor out_ready reaches any output combinationally.
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK-1:0]       sl_sum;
  logic                   sl_cout;
  logic                   sl_cmsb;
  logic [WIDTH+CHUNK-1:0] res_cat;

  chunk_slice #(.CHUNK(CHUNK)) u_slice (
    .sum     (sl_sum),
    .cout    (sl_cout),
    .cmsb_in (sl_cmsb),
    .a       (a_sh_q[CHUNK-1:0]),
    .b       (b_sh_q[CHUNK-1:0]),
    .cin     (carry_q)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    // New chunk enters at the top; after NCHUNK shifts chunk 0 sits at bit 0.
    res_cat = {sl_sum, res_q};

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> CHUNK;
        b_sh_d  = b_sh_q >> CHUNK;
        res_d   = res_cat[WIDTH+CHUNK-1:CHUNK];
        carry_d = sl_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          cout_d  = sl_cout;
          ovf_d   = sl_cout ^ sl_cmsb;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = res_q;
  assign cout      = cout_q;
  assign over_flow = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_chunk_adder_seq.sv
// Bench for chunk_adder_seq: directed literal cases plus random traffic against
// an arithmetic reference model, checked every cycle by one compare process.
module tb_chunk_adder_seq;

  localparam int W      = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = W / CHUNK;
  localparam int N_RAND = 300;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         over_flow;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [1:0]   flg_q[$];
  bit           busy = 1'b0;
  int           acc_cyc = 0;

  chunk_adder_seq #(.WIDTH(W), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .over_flow (over_flow),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Returns {cout, overflow, sum} from plain wide arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
    ov   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {full[W], ov, full[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic exp_valid;
    logic [W+1:0] m;
    if (!rst_n) begin
      busy = 1'b0;
      exp_q.delete();
      flg_q.delete();
    end else begin
      exp_valid = busy && (cyc >= acc_cyc + NCHUNK);
      check("in_ready", W'(in_ready), W'(!busy));
      check("out_valid", W'(out_valid), W'(exp_valid));
      if (out_valid && exp_valid && exp_q.size() > 0) begin
        check("sum", sum, exp_q[0]);
        check("cout", W'(cout), W'(flg_q[0][1]));
        check("over_flow", W'(over_flow), W'(flg_q[0][0]));
      end
      if (in_valid && !busy) begin
        m = model(a, b, cin, sub);
        exp_q.push_back(m[W-1:0]);
        flg_q.push_back(m[W+1:W]);
        busy    = 1'b1;
        acc_cyc = cyc + 1;
      end else if (busy && exp_valid && out_valid && out_ready) begin
        void'(exp_q.pop_front());
        void'(flg_q.pop_front());
        busy = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // Runs one operation; 'pin' additionally compares against literal results.
  task automatic do_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                       input logic cin_i, input logic sub_i, input int hold,
                       input bit pin, input logic [W-1:0] e_sum,
                       input logic e_co, input logic e_ov, input bit chk_lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end
    a = a_i; b = b_i; cin = cin_i; sub = sub_i; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < NCHUNK + 8) begin
      a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    if (!out_valid) begin
      errors++; checks++;
      $display("FAIL result_timeout: out_valid=0 after %0d cycles, expected 1", n);
    end
    if (chk_lat) check("latency", W'(n), W'(NCHUNK));
    if (pin) begin
      check("lit_sum", sum, e_sum);
      check("lit_cout", W'(cout), W'(e_co));
      check("lit_ovf", W'(over_flow), W'(e_ov));
    end
    for (int i = 0; i < hold; i++) begin
      a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [W+1:0] pm;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_sum", sum, '0);
    check("rst_cout", W'(cout), W'(0));
    check("rst_ovf", W'(over_flow), W'(0));
    check("rst_state", W'(dbg_state), W'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // pin the model against hand-computed values
    pm = model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    check("model_ovf_add", pm, {2'b01, 32'h8000_0000});
    pm = model(32'h8000_0000, 32'h1, 1'b1, 1'b1);
    check("model_ovf_sub", pm, {2'b11, 32'h7FFF_FFFF});

    do_op(32'h0000_00FF, 32'h1, 1'b0, 1'b0, 0, 1, 32'h0000_0100, 1'b0, 1'b0, 1);
    do_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0, 1, 32'h8000_0000, 1'b0, 1'b1, 1);
    do_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1, 1, 32'h0000_0000, 1'b1, 1'b0, 1);
    do_op(32'h5, 32'h7, 1'b1, 1'b1, 0, 1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    do_op(32'h8000_0000, 32'h1, 1'b1, 1'b1, 0, 1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1);
    // backpressure: 10 held cycles with scrambled inputs
    do_op(32'h1234_0000, 32'h0000_ABCD, 1'b0, 1'b0, 10, 1, 32'h1234_ABCD, 1'b0, 1'b0, 1);
    check("post_hs_in_ready", W'(in_ready), W'(1));

    // reset abort mid-run
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", W'(in_ready), W'(1));
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_sum", sum, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (NCHUNK + 4) @(posedge clk);
    #1;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 0, 1, 32'h2345_6789, 1'b0, 1'b0, 1);

    // random traffic with random backpressure and gaps
    for (int i = 0; i < N_RAND; i++) begin
      do_op(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 4), 0, '0, 1'b0, 1'b0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
